// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_sequencer #(
  parameter int NB_DATA  = 32,
  parameter int NB_FCODE = 6,
  parameter int NB_COUNT = 6,
  parameter logic [NB_FCODE-1:0] MFHI_FCODE  = 6'h10,
  parameter logic [NB_FCODE-1:0] MTHI_FCODE  = 6'h11,
  parameter logic [NB_FCODE-1:0] MFLO_FCODE  = 6'h12,
  parameter logic [NB_FCODE-1:0] MTLO_FCODE  = 6'h13,
  parameter logic [NB_FCODE-1:0] MULT_FCODE  = 6'h18,
  parameter logic [NB_FCODE-1:0] MULTU_FCODE = 6'h19,
  parameter logic [NB_FCODE-1:0] DIV_FCODE   = 6'h1a,
  parameter logic [NB_FCODE-1:0] DIVU_FCODE  = 6'h1b
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_FCODE-1:0] i_function_code,
  input  logic [NB_DATA-1:0]  i_rs_data,
  input  logic [NB_DATA-1:0]  i_rt_data,
  output logic                o_stall,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_div_by_zero,
  output logic [NB_DATA-1:0]  o_hilo_data,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [NB_COUNT-1:0] LAST_STEP = NB_COUNT'(NB_DATA - 1);

  state_t state;
  state_t next_state;

  logic [NB_DATA-1:0]  hi;
  logic [NB_DATA-1:0]  lo;
  logic [NB_DATA-1:0]  acc;
  logic [NB_DATA-1:0]  quo;
  logic [NB_DATA-1:0]  opnd;
  logic [NB_COUNT-1:0] counter;
  logic                busy;
  logic                done;
  logic                div_by_zero;
  logic                op_div;
  logic                zero_div;
  logic                neg_result;
  logic                neg_rem;

  logic                is_mult;
  logic                is_div;
  logic                is_md;
  logic                is_hilo;
  logic                signed_op;
  logic                rs_neg;
  logic                rt_neg;
  logic [NB_DATA-1:0]  rs_mag;
  logic [NB_DATA-1:0]  rt_mag;
  logic                start_zero_div;

  logic [NB_DATA:0]    mult_sum;
  logic [NB_DATA:0]    div_shift;
  logic                div_fits;
  logic [NB_DATA-1:0]  div_diff;

  logic [2*NB_DATA-1:0] product;
  logic [2*NB_DATA-1:0] product_fixed;
  logic [NB_DATA-1:0]   quo_fixed;
  logic [NB_DATA-1:0]   rem_fixed;

  always_comb begin
    is_mult = i_valid & ((i_function_code == MULT_FCODE) | (i_function_code == MULTU_FCODE));
    is_div  = i_valid & ((i_function_code == DIV_FCODE)  | (i_function_code == DIVU_FCODE));
    is_md   = is_mult | is_div;
    is_hilo = i_valid & ((i_function_code == MFHI_FCODE) | (i_function_code == MTHI_FCODE) |
                         (i_function_code == MFLO_FCODE) | (i_function_code == MTLO_FCODE));
    o_stall = busy & (is_md | is_hilo);
  end

  always_comb begin
    signed_op      = (i_function_code == MULT_FCODE) | (i_function_code == DIV_FCODE);
    rs_neg         = signed_op & i_rs_data[NB_DATA-1];
    rt_neg         = signed_op & i_rt_data[NB_DATA-1];
    rs_mag         = rs_neg ? -i_rs_data : i_rs_data;
    rt_mag         = rt_neg ? -i_rt_data : i_rt_data;
    start_zero_div = is_div & (i_rt_data == '0);
  end

  // One iteration of each algorithm; acc is the product high half or the partial remainder.
  always_comb begin
    mult_sum  = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, quo[NB_DATA-1]};
    div_fits  = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[NB_DATA-1:0] - opnd;
  end

  always_comb begin
    product       = {acc, quo};
    product_fixed = neg_result ? -product : product;
    quo_fixed     = neg_result ? -quo : quo;
    rem_fixed     = neg_rem ? -acc : acc;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (is_md) begin
          next_state = start_zero_div ? FIX : RUN;
        end
      end
      RUN: begin
        if (counter == LAST_STEP) begin
          next_state = FIX;
        end
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      hi          <= '0;
      lo          <= '0;
      acc         <= '0;
      quo         <= '0;
      opnd        <= '0;
      counter     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      op_div      <= 1'b0;
      zero_div    <= 1'b0;
      neg_result  <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (is_md) begin
            op_div   <= is_div;
            zero_div <= start_zero_div;
            counter  <= '0;
            busy     <= 1'b1;
            if (is_mult) begin
              acc        <= '0;
              quo        <= rt_mag;
              opnd       <= rs_mag;
              neg_result <= rs_neg ^ rt_neg;
              neg_rem    <= 1'b0;
            end else if (start_zero_div) begin
              // Raw dividend parked in acc so FIX can hand it straight to HI.
              acc        <= i_rs_data;
              quo        <= '0;
              opnd       <= '0;
              neg_result <= 1'b0;
              neg_rem    <= 1'b0;
            end else begin
              acc        <= '0;
              quo        <= rs_mag;
              opnd       <= rt_mag;
              neg_result <= rs_neg ^ rt_neg;
              neg_rem    <= rs_neg;
            end
          end else if (i_valid && (i_function_code == MTHI_FCODE)) begin
            hi <= i_rs_data;
          end else if (i_valid && (i_function_code == MTLO_FCODE)) begin
            lo <= i_rs_data;
          end
        end
        RUN: begin
          counter <= counter + NB_COUNT'(1);
          if (op_div) begin
            if (div_fits) begin
              acc <= div_diff;
              quo <= {quo[NB_DATA-2:0], 1'b1};
            end else begin
              acc <= div_shift[NB_DATA-1:0];
              quo <= {quo[NB_DATA-2:0], 1'b0};
            end
          end else begin
            acc <= mult_sum[NB_DATA:1];
            quo <= {mult_sum[0], quo[NB_DATA-1:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_div) begin
            hi          <= acc;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (op_div) begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end else begin
            {hi, lo} <= product_fixed;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_hilo_data = '0;
    if (i_valid && (i_function_code == MFHI_FCODE)) begin
      o_hilo_data = hi;
    end else if (i_valid && (i_function_code == MFLO_FCODE)) begin
      o_hilo_data = lo;
    end
  end

  assign o_busy        = busy;
  assign o_done        = done;
  assign o_div_by_zero = div_by_zero;
  assign o_hi          = hi;
  assign o_lo          = lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic [5:0]  i_function_code;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic        o_stall;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;
  logic [31:0] o_hilo_data;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_sequencer dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_function_code(i_function_code),
    .i_rs_data(i_rs_data),
    .i_rt_data(i_rt_data),
    .o_stall(o_stall),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_div_by_zero(o_div_by_zero),
    .o_hilo_data(o_hilo_data),
    .o_hi(o_hi),
    .o_lo(o_lo)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  task automatic ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (f)
      6'h18: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      6'h19: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (f == 6'h1a) begin
          q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1 of the done cycle.
  task automatic do_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    logic        edz;
    int          cycles;
    ref_md(f, a, b, ehi, elo, edz);
    i_valid = 1'b1; i_function_code = f; i_rs_data = a; i_rt_data = b;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    cycles = 0;
    while (o_busy && cycles < 100) begin
      cycles++;
      @(posedge i_clock); #1;
    end
    check({tag, "_busy_cycles"}, 64'(cycles), edz ? 64'd1 : 64'd33);
    check({tag, "_done"}, 64'(o_done), 64'd1);
    check({tag, "_dz"}, 64'(o_div_by_zero), 64'(edz));
    check({tag, "_hi"}, 64'(o_hi), 64'(ehi));
    check({tag, "_lo"}, 64'(o_lo), 64'(elo));
  endtask

  initial begin
    logic [31:0] ehi, elo, a, b;
    logic        edz;
    logic [5:0]  f;
    int          k, dones;

    i_reset = 1'b0; i_valid = 1'b0; i_function_code = '0; i_rs_data = '0; i_rt_data = '0;
    repeat (3) @(posedge i_clock);
    #1;
    i_valid = 1'b1; i_function_code = 6'h10;
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_hi", 64'(o_hi), 64'd0);
    check("rst_lo", 64'(o_lo), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_mfhi", 64'(o_hilo_data), 64'd0);
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clock); #1;

    // Moves to and from HI/LO
    i_valid = 1'b1; i_function_code = 6'h11; i_rs_data = 32'hCAFE_0001;
    @(posedge i_clock); #1;
    i_function_code = 6'h13; i_rs_data = 32'h0BAD_F00D;
    @(posedge i_clock); #1;
    i_function_code = 6'h10;
    #1 check("mthi_mfhi", 64'(o_hilo_data), 64'hCAFE_0001);
    i_function_code = 6'h12;
    #1 check("mtlo_mflo", 64'(o_hilo_data), 64'h0BAD_F00D);
    i_function_code = 6'h20;
    #1 check("other_hilo", 64'(o_hilo_data), 64'd0);
    i_valid = 1'b0;
    @(posedge i_clock); #1;

    do_md("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_md("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7);
    do_md("div_neg", 6'h1a, 32'hFFFF_FFF9, 32'd2);
    do_md("divu", 6'h1b, 32'd100, 32'd7);
    do_md("divu_zero", 6'h1b, 32'h0000_1234, 32'd0);
    do_md("div_zero", 6'h1a, 32'h8000_0005, 32'd0);
    do_md("div_wrap", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
    check("done_one_cycle_pre", 64'(o_done), 64'd1);
    @(posedge i_clock); #1;
    check("done_one_cycle", 64'(o_done), 64'd0);

    // Randomized back-to-back operations: each new op is issued in the previous done cycle.
    for (int i = 0; i < 30; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = 32'(-$urandom_range(1, 20));
        default: ;
      endcase
      do_md($sformatf("rand%0d", i), f, a, b);
    end

    // Unrelated instruction flows, MFLO stalls until the done cycle.
    @(posedge i_clock); #1;
    a = 32'h1357_9BDF; b = 32'hFEDC_BA98;
    ref_md(6'h18, a, b, ehi, elo, edz);
    i_valid = 1'b1; i_function_code = 6'h18; i_rs_data = a; i_rt_data = b;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    @(posedge i_clock); #1;
    i_valid = 1'b1; i_function_code = 6'h20;
    #1 check("add_no_stall", 64'(o_stall), 64'd0);
    check("add_busy", 64'(o_busy), 64'd1);
    i_valid = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    i_valid = 1'b1; i_function_code = 6'h12;
    #1;
    k = 0;
    while (o_busy && k < 100) begin
      check("mflo_stall", 64'(o_stall), 64'd1);
      k++;
      @(posedge i_clock); #2;
    end
    check("mflo_stall_cycles", 64'(k), 64'd29);
    check("mflo_done", 64'(o_done), 64'd1);
    check("mflo_release", 64'(o_stall), 64'd0);
    check("mflo_data", 64'(o_hilo_data), 64'(elo));
    i_valid = 1'b0;
    @(posedge i_clock); #1;

    // Reset in the middle of RUN abandons the operation.
    i_valid = 1'b1; i_function_code = 6'h19; i_rs_data = 32'hFFFF_0000; i_rt_data = 32'h1234_5678;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_hi", 64'(o_hi), 64'd0);
    check("midrst_lo", 64'(o_lo), 64'd0);
    i_reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge i_clock); #1;
      if (o_done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_idle_busy", 64'(o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit in the EX stage, beside the single-cycle ALU. Executes MULT, MULTU, DIV and DIVU over NB_DATA+1 cycles and owns the HI/LO registers.
- Also handles MTHI, MTLO, MFHI and MFLO.
- Stalls the pipeline only when an instruction touches HI/LO or the unit while an operation is in flight. Unrelated instructions keep flowing.

Parameters:
- NB_DATA, 32, operand/HI/LO width
- NB_FCODE, 6, function code width
- NB_COUNT, 6, iteration counter width (must hold NB_DATA)
- MFHI_FCODE, 6'h10, move from HI
- MTHI_FCODE, 6'h11, move to HI
- MFLO_FCODE, 6'h12, move from LO
- MTLO_FCODE, 6'h13, move to LO
- MULT_FCODE, 6'h18, signed multiply
- MULTU_FCODE, 6'h19, unsigned multiply
- DIV_FCODE, 6'h1a, signed divide
- DIVU_FCODE, 6'h1b, unsigned divide

Ports:
- i_clock  in  1  clock; all state changes on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_valid  in  1  R-type instruction present in EX (opcode 6'h00, not flushed)
- i_function_code  in  NB_FCODE  funct field
- i_rs_data  in  NB_DATA  rs operand (multiplicand/dividend/MTxx source)
- i_rt_data  in  NB_DATA  rt operand (multiplier/divisor)
- o_stall  out  1  combinational; hold IF/ID/EX, bubble MEM
- o_busy  out  1  registered; operation in flight
- o_done  out  1  registered one-cycle pulse; HI/LO updated this cycle
- o_div_by_zero  out  1  registered one-cycle pulse with o_done on a zero divisor
- o_hilo_data  out  NB_DATA  combinational; HI for MFHI, LO for MFLO, else 0
- o_hi  out  NB_DATA  HI register
- o_lo  out  NB_DATA  LO register

Behaviour:
- Reset (i_reset==0 at an edge, including mid-operation):
  - state=IDLE; HI=LO=0; counter=0; busy=done=div_by_zero=0.
  - Any operation in flight is abandoned.
- Decode: is_md = i_valid & funct∈{MULT,MULTU,DIV,DIVU}; is_hilo = i_valid & funct∈{MFHI,MTHI,MFLO,MTLO}.
- o_stall = o_busy & (is_md | is_hilo). Never asserted in IDLE.
- States:
  - IDLE:
    - is_md latches operands, sign flags and op; converts signed operands to magnitudes; counter=0; next RUN; busy=1.
    - Exception: DIV/DIVU with rt==0 goes to FIX directly, skipping RUN.
    - MTHI/MTLO write HI/LO at this edge.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments; after NB_DATA steps (counter==NB_DATA-1) next FIX.
  - FIX:
    - Negates the 2·NB_DATA product if signs differ (MULT).
    - DIV: negates the quotient if signs differ; the remainder takes the dividend sign.
    - Writes HI/LO; pulses o_done; busy=0; next IDLE.
- Results:
  - MULT*: {HI,LO} = 64-bit product.
  - DIV*: LO = quotient, HI = remainder, truncated toward zero.
- Latency:
  - Start accepted at edge t0; busy high for NB_DATA+1 cycles.
  - o_done high in the cycle after the FIX edge. HI/LO valid from that cycle.
  - An MFHI presented during busy stalls and completes in the done cycle.
- Divide by zero: after 1 busy cycle, HI = rs (unmodified), LO = all ones; o_div_by_zero pulses with o_done.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no exception).
- A new is_md arriving in the done cycle is accepted (state is IDLE).
- Stalled instructions are not latched; they are re-presented by the held pipeline.
- i_valid=0 or other funct: no effect on state.

Test Plan:
- Reset with no op -> HI=LO=0, busy=0, stall=0; MFHI -> o_hilo_data=0.
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy 33 cycles, then done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=-3 (0xFFFFFFFD) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV rs=-7 rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100 rt=7 -> LO=14, HI=2.
- DIVU rs=0x1234 rt=0 -> 1 busy cycle, done with div_by_zero=1; LO=0xFFFFFFFF, HI=0x1234.
- MULT started, then ADD (funct 0x20) on cycle 2 -> stall=0; MFLO on cycle 5 -> stall held until the done cycle, where o_hilo_data equals the new LO.
- Reset low at RUN cycle 10 -> next cycle busy=0, HI=LO=0, and no done pulse ever appears.
